// File: rtl/write_resp_tracker_pkg.sv
// Shared types and helpers for the ordered write-response tracker.
// Holds the AXI bresp encodings, the tracker FSM states and the response-merge rule.
package write_resp_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DELIVER = 2'd2
  } state_e;

  // The encodings are ordered by severity, so the merge is a plain unsigned max.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/write_resp_tracker_if.sv
// Push, slave-side B, master-side B and status signals of the write-response tracker.
// The slave modport is the tracker's view; the master modport is its environment's view.
interface write_resp_tracker_if #(
  parameter int Num_Of_Masters  = 2,
  parameter int Num_Of_Slaves   = 2,
  parameter int Burst_Cnt_Width = 4
);
  localparam int Master_ID_Width = $clog2(Num_Of_Masters);
  localparam int Slaves_ID_Size  = $clog2(Num_Of_Slaves);

  logic                       Wr_Done;
  logic [Master_ID_Width-1:0] Wr_Master_ID;
  logic [Slaves_ID_Size-1:0]  Wr_Slave_ID;
  logic [Burst_Cnt_Width-1:0] Wr_Num_Bursts;
  logic [Num_Of_Slaves-1:0]   S_bvalid;
  logic [2*Num_Of_Slaves-1:0] S_bresp;
  logic [Num_Of_Slaves-1:0]   S_bready;
  logic [Num_Of_Masters-1:0]  M_bvalid;
  logic [1:0]                 M_bresp;
  logic [Num_Of_Masters-1:0]  M_bready;
  logic                       Queue_Full;
  logic                       Queue_Empty;
  logic                       Overflow_Err;

  modport slave (
    input  Wr_Done, Wr_Master_ID, Wr_Slave_ID, Wr_Num_Bursts,
    input  S_bvalid, S_bresp, M_bready,
    output S_bready, M_bvalid, M_bresp, Queue_Full, Queue_Empty, Overflow_Err
  );

  modport master (
    output Wr_Done, Wr_Master_ID, Wr_Slave_ID, Wr_Num_Bursts,
    output S_bvalid, S_bresp, M_bready,
    input  S_bready, M_bvalid, M_bresp, Queue_Full, Queue_Empty, Overflow_Err
  );
endinterface

// File: rtl/write_resp_tracker_fifo.sv
// Synchronous FIFO of outstanding write entries with head and next-head read ports.
// Fullness is judged before a same-cycle pop; a push while full is dropped and flagged sticky.
module resp_track_fifo #(
  parameter int Depth = 4,
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic [Width-1:0] next_dout,
  output logic [$clog2(Depth):0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop;
  logic [AW-1:0]    rd_next_idx;

  assign count       = wr_ptr_q - rd_ptr_q;
  assign full        = (count == (AW+1)'(Depth));
  assign empty       = (count == '0);
  assign do_push     = push & ~full;
  assign do_pop      = pop & ~empty;
  assign rd_next_idx = rd_ptr_q[AW-1:0] + AW'(1);
  assign dout        = mem[rd_ptr_q[AW-1:0]];
  assign next_dout   = mem[rd_next_idx];
  assign overflow    = ovf_q;

  // NOTE: every variable gets a default before any condition so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    ovf_d    = ovf_q | (push & full);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which words are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/write_resp_tracker.sv
// Ordered write-response tracker: accepts B responses only from the head entry's slave,
// merges split bursts by severity and returns one response to the owning master.
module write_resp_tracker
  import write_resp_pkg::*;
#(
  parameter int Num_Of_Masters  = 2,
  parameter int Master_ID_Width = $clog2(Num_Of_Masters),
  parameter int Num_Of_Slaves   = 2,
  parameter int Slaves_ID_Size  = $clog2(Num_Of_Slaves),
  parameter int Depth           = 4,
  parameter int Burst_Cnt_Width = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  write_resp_tracker_if.slave  bus
);
  localparam int EntW   = Master_ID_Width + Slaves_ID_Size + Burst_Cnt_Width;
  localparam int SlvLsb = Burst_Cnt_Width;
  localparam int MstLsb = Burst_Cnt_Width + Slaves_ID_Size;
  localparam int CntW   = $clog2(Depth) + 1;

  logic [EntW-1:0] push_ent, head_ent, next_ent, load_ent;
  logic [CntW-1:0] fifo_count;
  logic            fifo_full, fifo_empty, fifo_ovf;
  logic            pop, load;
  logic [1:0]      slave_resp;
  logic [Slaves_ID_Size-1:0]  ld_slave;
  logic [Burst_Cnt_Width-1:0] ld_nb;

  state_e                     state_q, state_d;
  logic [Burst_Cnt_Width-1:0] cnt_q, cnt_d;
  logic [1:0]                 acc_q, acc_d;
  logic [Master_ID_Width-1:0] head_master_q, head_master_d;
  logic [Slaves_ID_Size-1:0]  head_slave_q, head_slave_d;
  logic [Num_Of_Slaves-1:0]   s_bready_q, s_bready_d;
  logic [Num_Of_Masters-1:0]  m_bvalid_q, m_bvalid_d;
  logic [1:0]                 m_bresp_q, m_bresp_d;

  assign push_ent   = {bus.Wr_Master_ID, bus.Wr_Slave_ID, bus.Wr_Num_Bursts};
  assign slave_resp = bus.S_bresp[2*head_slave_q +: 2];

  resp_track_fifo #(.Depth(Depth), .Width(EntW)) u_fifo (
    .clk       (ACLK),
    .rst       (ARESETN),
    .push      (bus.Wr_Done),
    .pop       (pop),
    .din       (push_ent),
    .dout      (head_ent),
    .next_dout (next_ent),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    head_master_d = head_master_q;
    head_slave_d  = head_slave_q;
    s_bready_d    = s_bready_q;
    m_bvalid_d    = m_bvalid_q;
    m_bresp_d     = m_bresp_q;
    pop           = 1'b0;
    load          = 1'b0;
    load_ent      = '0;
    ld_slave      = '0;
    ld_nb         = '0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          load     = 1'b1;
          load_ent = head_ent;
        end else if (bus.Wr_Done) begin
          load     = 1'b1;
          load_ent = push_ent;
        end
      end
      COLLECT: begin
        if (bus.S_bvalid[head_slave_q] && s_bready_q[head_slave_q]) begin
          acc_d = resp_merge(acc_q, slave_resp);
          if (cnt_q == Burst_Cnt_Width'(1)) begin
            state_d                   = DELIVER;
            s_bready_d                = '0;
            m_bvalid_d                = '0;
            m_bvalid_d[head_master_q] = 1'b1;
            m_bresp_d                 = acc_d;
          end else begin
            cnt_d = cnt_q - Burst_Cnt_Width'(1);
          end
        end
      end
      DELIVER: begin
        if (bus.M_bready[head_master_q] && m_bvalid_q[head_master_q]) begin
          pop        = 1'b1;
          m_bvalid_d = '0;
          m_bresp_d  = OKAY;
          // The next head is either already queued or arriving this very cycle.
          if (fifo_count > CntW'(1)) begin
            load     = 1'b1;
            load_ent = next_ent;
          end else if (bus.Wr_Done) begin
            load     = 1'b1;
            load_ent = push_ent;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      ld_slave               = load_ent[SlvLsb +: Slaves_ID_Size];
      ld_nb                  = load_ent[Burst_Cnt_Width-1:0];
      state_d                = COLLECT;
      head_master_d          = load_ent[MstLsb +: Master_ID_Width];
      head_slave_d           = ld_slave;
      cnt_d                  = (ld_nb == '0) ? Burst_Cnt_Width'(1) : ld_nb;
      acc_d                  = OKAY;
      s_bready_d             = '0;
      s_bready_d[ld_slave]   = 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESETN) begin
    if (ARESETN) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= OKAY;
      head_master_q <= '0;
      head_slave_q  <= '0;
      s_bready_q    <= '0;
      m_bvalid_q    <= '0;
      m_bresp_q     <= OKAY;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      head_master_q <= head_master_d;
      head_slave_q  <= head_slave_d;
      s_bready_q    <= s_bready_d;
      m_bvalid_q    <= m_bvalid_d;
      m_bresp_q     <= m_bresp_d;
    end
  end

  assign bus.S_bready     = s_bready_q;
  assign bus.M_bvalid     = m_bvalid_q;
  assign bus.M_bresp      = m_bresp_q;
  assign bus.Queue_Full   = fifo_full;
  assign bus.Queue_Empty  = fifo_empty;
  assign bus.Overflow_Err = fifo_ovf;

endmodule

// File: tb/tb_write_resp_tracker.sv
// Self-checking bench for write_resp_tracker: directed scenarios then random traffic,
// every cycle compared against a queue-of-transactions reference model.
module tb_write_resp_tracker;
  localparam int NM    = 2;
  localparam int NS    = 2;
  localparam int DEPTH = 4;
  localparam int BW    = 4;
  localparam int MW    = $clog2(NM);
  localparam int SW    = $clog2(NS);

  logic aclk    = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  write_resp_tracker_if #(.Num_Of_Masters(NM), .Num_Of_Slaves(NS), .Burst_Cnt_Width(BW)) bus ();

  write_resp_tracker #(
    .Num_Of_Masters(NM), .Num_Of_Slaves(NS), .Depth(DEPTH), .Burst_Cnt_Width(BW)
  ) dut (
    .ACLK    (aclk),
    .ARESETN (aresetn),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: outstanding transactions in push order; the head collects until
  // it has seen all its bursts, then it is offered to its master until accepted.
  typedef struct {
    int master;
    int slave;
    int nb;
    int got;
    int acc;
  } ent_t;

  ent_t mq[$];
  bit   ovf_m = 1'b0;

  task automatic check_outputs(input string tag);
    logic [NS-1:0] esb;
    logic [NM-1:0] emv;
    logic [1:0]    emr;
    esb = '0;
    emv = '0;
    emr = 2'b00;
    if (mq.size() > 0) begin
      if (mq[0].got < mq[0].nb) esb[mq[0].slave] = 1'b1;
      else begin
        emv[mq[0].master] = 1'b1;
        emr = 2'(mq[0].acc);
      end
    end
    check({tag, ".s_bready"}, bus.S_bready, esb);
    check({tag, ".m_bvalid"}, bus.M_bvalid, emv);
    check({tag, ".m_bresp"},  bus.M_bresp,  emr);
    check({tag, ".full"},     bus.Queue_Full,   mq.size() == DEPTH);
    check({tag, ".empty"},    bus.Queue_Empty,  mq.size() == 0);
    check({tag, ".ovf"},      bus.Overflow_Err, ovf_m);
  endtask

  task automatic drive_idle();
    bus.Wr_Done       = 1'b0;
    bus.Wr_Master_ID  = '0;
    bus.Wr_Slave_ID   = '0;
    bus.Wr_Num_Bursts = '0;
    bus.S_bvalid      = '0;
    bus.S_bresp       = '0;
    bus.M_bready      = '0;
  endtask

  // One clock: drive at the falling edge, check, advance the model, step to next falling edge.
  task automatic cycle(input string tag, input bit wd, input int wm, input int ws, input int wn,
                       input logic [NS-1:0] sv, input logic [2*NS-1:0] sr,
                       input logic [NM-1:0] mr);
    int   sz;
    int   r;
    bit   do_pop;
    ent_t h;
    ent_t e;
    bus.Wr_Done       = wd;
    bus.Wr_Master_ID  = MW'(wm);
    bus.Wr_Slave_ID   = SW'(ws);
    bus.Wr_Num_Bursts = BW'(wn);
    bus.S_bvalid      = sv;
    bus.S_bresp       = sr;
    bus.M_bready      = mr;
    check_outputs(tag);

    sz     = mq.size();
    do_pop = 1'b0;
    if (sz > 0) begin
      h = mq[0];
      if (h.got < h.nb) begin
        if (sv[h.slave]) begin
          r = int'(sr[2*h.slave +: 2]);
          if (r > h.acc) h.acc = r;
          h.got++;
        end
      end else if (mr[h.master]) begin
        do_pop = 1'b1;
      end
      mq[0] = h;
    end
    if (do_pop) void'(mq.pop_front());
    if (wd) begin
      if (sz == DEPTH) ovf_m = 1'b1;
      else begin
        e.master = wm;
        e.slave  = ws;
        e.nb     = (wn == 0) ? 1 : wn;
        e.got    = 0;
        e.acc    = 0;
        mq.push_back(e);
      end
    end
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic apply_reset();
    aresetn = 1'b1;
    mq.delete();
    ovf_m = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b0;
  endtask

  initial begin
    drive_idle();
    #1;
    check_outputs("reset");
    apply_reset();
    check_outputs("post_reset");

    // Unsplit write: M1 -> S0, single OKAY response.
    cycle("unsplit_push", 1, 1, 0, 1, 2'b00, 4'b0000, 2'b00);
    cycle("unsplit_sresp", 0, 0, 0, 0, 2'b01, 4'b0000, 2'b00);
    check("unsplit_mvalid_onehot", bus.M_bvalid, 2'b10);
    cycle("unsplit_mresp", 0, 0, 0, 0, 2'b00, 4'b0000, 2'b10);
    cycle("unsplit_done", 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00);

    // Split write: M0 -> S1, three bursts 00,10,00 merged to SLVERR; then 5 cycles of backpressure.
    cycle("split_push", 1, 0, 1, 3, 2'b00, 4'b0000, 2'b00);
    cycle("split_b0", 0, 0, 0, 0, 2'b10, 4'b0000, 2'b00);
    cycle("split_gap", 0, 0, 0, 0, 2'b00, 4'b1100, 2'b01);
    cycle("split_b1", 0, 0, 0, 0, 2'b10, 4'b1000, 2'b00);
    cycle("split_b2", 0, 0, 0, 0, 2'b10, 4'b0000, 2'b00);
    check("split_merged_resp", bus.M_bresp, 2'b10);
    for (int i = 0; i < 5; i++) cycle("backpressure", 0, 0, 0, 0, 2'b11, 4'b1111, 2'b10);
    cycle("split_accept", 0, 0, 0, 0, 2'b00, 4'b0000, 2'b01);

    // Ordering: S0 answers early but must wait for M0's S1 entry to finish.
    cycle("order_push0", 1, 0, 1, 1, 2'b00, 4'b0000, 2'b00);
    cycle("order_push1", 1, 1, 0, 1, 2'b01, 4'b0011, 2'b00);
    for (int i = 0; i < 3; i++) cycle("order_stall", 0, 0, 0, 0, 2'b01, 4'b0011, 2'b00);
    check("order_s0_stalled", bus.S_bready, 2'b10);
    cycle("order_s1", 0, 0, 0, 0, 2'b11, 4'b0111, 2'b00);
    for (int i = 0; i < 4; i++) cycle("order_drain", 0, 0, 0, 0, 2'b11, 4'b0111, 2'b11);

    // Overflow: four pushes fill the queue, the fifth is dropped.
    for (int i = 0; i < 5; i++) cycle("ovf_push", 1, i % 2, (i + 1) % 2, 1, 2'b00, 4'b0000, 2'b00);
    check("ovf_full", bus.Queue_Full, 1'b1);
    for (int i = 0; i < 16; i++) cycle("ovf_drain", 0, 0, 0, 0, 2'b11, 4'b1001, 2'b11);
    check("ovf_sticky", bus.Overflow_Err, 1'b1);

    // Reset in COLLECT after one of two bursts: outputs clear asynchronously.
    apply_reset();
    cycle("rst_push", 1, 0, 1, 2, 2'b00, 4'b0000, 2'b00);
    cycle("rst_b0", 0, 0, 0, 0, 2'b10, 4'b1100, 2'b00);
    aresetn = 1'b1;
    #1;
    mq.delete();
    ovf_m = 1'b0;
    check_outputs("rst_async");
    @(negedge aclk);
    drive_idle();
    aresetn = 1'b0;
    cycle("rst_fresh_push", 1, 1, 0, 1, 2'b00, 4'b0000, 2'b00);
    cycle("rst_fresh_sresp", 0, 0, 0, 0, 2'b01, 4'b0000, 2'b00);
    cycle("rst_fresh_mresp", 0, 0, 0, 0, 2'b00, 4'b0000, 2'b10);
    cycle("rst_fresh_done", 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle("rand",
            ($urandom_range(0, 99) < 35),
            int'($urandom_range(0, NM - 1)),
            int'($urandom_range(0, NS - 1)),
            int'($urandom_range(0, 4)),
            NS'($urandom),
            (2*NS)'($urandom),
            NM'($urandom));
    end
    drive_idle();
    for (int i = 0; i < 4; i++) cycle("tail", 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
